// File: rtl/machine_timer_pkg.sv
// machine_timer_pkg: register offsets, reset constants and byte-merge helper shared by the machine timer
package machine_timer_pkg;
    localparam logic [4:0]  OFFSET_MTIME_LO    = 5'h00;
    localparam logic [4:0]  OFFSET_MTIME_HI    = 5'h04;
    localparam logic [4:0]  OFFSET_MTIMECMP_LO = 5'h08;
    localparam logic [4:0]  OFFSET_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0]  OFFSET_MSIP        = 5'h10;
    localparam logic [63:0] MTIMECMP_RESET     = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] merge_strobe(
        input logic [31:0] old_value,
        input logic [31:0] new_value,
        input logic [3:0]  strobe
    );
        logic [31:0] result;
        for (int i = 0; i < 4; i++)
            result[8*i +: 8] = strobe[i] ? new_value[8*i +: 8] : old_value[8*i +: 8];
        return result;
    endfunction
endpackage

// File: rtl/machine_timer_counter.sv
// machine_timer_counter: 64-bit mtime with half-word store ports and tick generation
// Build option: MACHINE_TIMER_PRESCALER_EN adds a PRESCALE-cycle prescaler in front of the increment.
module machine_timer_counter
    import machine_timer_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_write_lo,
    input  logic        i_write_hi,
    input  logic [31:0] i_write_data,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtime_next
);
    logic [63:0] r_mtime;
    logic        w_tick;

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("machine_timer_counter: PRESCALE must be within 1..65535");
    end

`ifdef MACHINE_TIMER_PRESCALER_EN
    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);
    logic [15:0] r_prescale;

    assign w_tick = r_prescale == PRESCALE_LAST;

    // Prescale phase advances every cycle, wraps after PRESCALE-1 and restarts on any mtime store
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_prescale <= '0;
        else
            r_prescale <= (i_write_lo || i_write_hi || w_tick) ? 16'd0 : r_prescale + 16'd1;
    end
`else
    assign w_tick = 1'b1;
`endif

    // A store replaces one half and freezes the other; otherwise a tick increments with full carry
    always_comb begin
        o_mtime_next = i_write_lo ? {r_mtime[63:32], i_write_data} :
                       i_write_hi ? {i_write_data, r_mtime[31:0]} :
                       w_tick     ? r_mtime + 64'd1 : r_mtime;
    end

    // Counter state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_mtime <= '0;
        else
            r_mtime <= o_mtime_next;
    end

    assign o_mtime = r_mtime;
endmodule

// File: rtl/machine_timer.sv
// machine_timer: CLINT-style mtime/mtimecmp/msip block with single-cycle bus response
// Build option: MACHINE_TIMER_PRESCALER_EN enables the mtime prescaler (see machine_timer_counter).
module machine_timer
    import machine_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0200_0000,
    parameter int unsigned PRESCALE     = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        request_valid,
    input  logic        request_write,
    input  logic [31:0] request_address,
    input  logic [3:0]  request_strobe,
    input  logic [31:0] request_write_data,
    output logic        response_valid,
    output logic [31:0] response_read_data,
    output logic        response_error,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        timer_interrupt,
    output logic        software_interrupt
);
    logic [4:0]  w_offset;
    logic        w_hit;
    logic        w_misaligned;
    logic        w_mapped;
    logic        w_access;
    logic        w_store;
    logic [31:0] w_read_value;
    logic [31:0] w_counter_data;
    logic [63:0] w_mtime;
    logic [63:0] w_mtime_next;
    logic [63:0] w_mtimecmp_next;
    logic        w_msip_next;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic        r_timer_interrupt;
    logic        r_response_valid;
    logic [31:0] r_response_read_data;
    logic        r_response_error;

    assign w_offset     = request_address[4:0];
    assign w_hit        = request_valid && request_address[31:5] == BASE_ADDRESS[31:5];
    assign w_misaligned = request_address[1:0] != 2'b00;
    assign w_mapped     = w_offset <= OFFSET_MSIP;
    assign w_access     = w_hit && !w_misaligned && w_mapped;
    assign w_store      = w_access && request_write;

    assign w_counter_data = merge_strobe(w_offset == OFFSET_MTIME_HI ? w_mtime[63:32] : w_mtime[31:0],
                                         request_write_data, request_strobe);

    machine_timer_counter #(.PRESCALE(PRESCALE)) u_counter (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_write_lo  (w_store && w_offset == OFFSET_MTIME_LO),
        .i_write_hi  (w_store && w_offset == OFFSET_MTIME_HI),
        .i_write_data(w_counter_data),
        .o_mtime     (w_mtime),
        .o_mtime_next(w_mtime_next)
    );

    // Load data reflects register contents before this cycle's store or tick
    always_comb begin
        w_read_value = (!w_access || request_write)      ? 32'd0 :
                       w_offset == OFFSET_MTIME_LO    ? w_mtime[31:0] :
                       w_offset == OFFSET_MTIME_HI    ? w_mtime[63:32] :
                       w_offset == OFFSET_MTIMECMP_LO ? r_mtimecmp[31:0] :
                       w_offset == OFFSET_MTIMECMP_HI ? r_mtimecmp[63:32] : {31'd0, r_msip};
    end

    // Next compare value and software-pending bit after byte-merged stores
    always_comb begin
        w_mtimecmp_next = (w_store && w_offset == OFFSET_MTIMECMP_LO) ?
                              {r_mtimecmp[63:32], merge_strobe(r_mtimecmp[31:0], request_write_data, request_strobe)} :
                          (w_store && w_offset == OFFSET_MTIMECMP_HI) ?
                              {merge_strobe(r_mtimecmp[63:32], request_write_data, request_strobe), r_mtimecmp[31:0]} :
                              r_mtimecmp;
        w_msip_next = (w_store && w_offset == OFFSET_MSIP && request_strobe[0]) ? request_write_data[0] : r_msip;
    end

    // Compare state; the interrupt level is computed from post-update values so it tracks mtime >= mtimecmp
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mtimecmp        <= MTIMECMP_RESET;
            r_msip            <= 1'b0;
            r_timer_interrupt <= 1'b0;
        end else begin
            r_mtimecmp        <= w_mtimecmp_next;
            r_msip            <= w_msip_next;
            r_timer_interrupt <= w_mtime_next >= w_mtimecmp_next;
        end
    end

    // One-cycle bus response; reset discards any response still in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_response_valid     <= 1'b0;
            r_response_read_data <= 32'd0;
            r_response_error     <= 1'b0;
        end else begin
            r_response_valid     <= request_valid;
            r_response_read_data <= w_read_value;
            r_response_error     <= w_hit && (w_misaligned || !w_mapped);
        end
    end

    assign response_valid     = r_response_valid;
    assign response_read_data = r_response_read_data;
    assign response_error     = r_response_error;
    assign mtime              = w_mtime;
    assign mtimecmp           = r_mtimecmp;
    assign timer_interrupt    = r_timer_interrupt;
    assign software_interrupt = r_msip;
endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: directed and random checks of machine_timer against a behavioural register model
module tb_machine_timer;
    localparam int P = 4;
`ifdef MACHINE_TIMER_PRESCALER_EN
    localparam int TPC = P;
`else
    localparam int TPC = 1;
`endif
    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        request_valid = 1'b0;
    logic        request_write = 1'b0;
    logic [31:0] request_address = 32'd0;
    logic [3:0]  request_strobe = 4'd0;
    logic [31:0] request_write_data = 32'd0;
    logic        response_valid;
    logic [31:0] response_read_data;
    logic        response_error;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        timer_interrupt;
    logic        software_interrupt;

    machine_timer #(.BASE_ADDRESS(BASE), .PRESCALE(P)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .request_valid     (request_valid),
        .request_write     (request_write),
        .request_address   (request_address),
        .request_strobe    (request_strobe),
        .request_write_data(request_write_data),
        .response_valid    (response_valid),
        .response_read_data(response_read_data),
        .response_error    (response_error),
        .mtime             (mtime),
        .mtimecmp          (mtimecmp),
        .timer_interrupt   (timer_interrupt),
        .software_interrupt(software_interrupt)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_msip;
    int          m_phase;
    logic        m_rv;
    logic        m_re;
    logic [31:0] m_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        for (int i = 0; i < 4; i++)
            if (s[i]) o[8*i +: 8] = n[8*i +: 8];
        return o;
    endfunction

    task automatic model_reset();
        m_mtime = 64'd0;
        m_cmp   = '1;
        m_msip  = 1'b0;
        m_phase = 0;
        m_rv    = 1'b0;
        m_re    = 1'b0;
        m_rd    = 32'd0;
    endtask

    task automatic model_cycle();
        logic       in_blk, good, st, tmw, tick;
        logic [4:0] off;
        if (!reset_n) begin
            model_reset();
            return;
        end
        in_blk = request_address[31:5] == BASE[31:5];
        off    = request_address[4:0];
        good   = in_blk && request_address[1:0] == 2'b00 && off <= 5'h10;
        m_rv   = request_valid;
        m_re   = request_valid && in_blk && !good;
        m_rd   = 32'd0;
        if (request_valid && good && !request_write)
            case (off)
                5'h00:   m_rd = m_mtime[31:0];
                5'h04:   m_rd = m_mtime[63:32];
                5'h08:   m_rd = m_cmp[31:0];
                5'h0C:   m_rd = m_cmp[63:32];
                default: m_rd = {31'd0, m_msip};
            endcase
        st  = request_valid && good && request_write;
        tmw = st && (off == 5'h00 || off == 5'h04);
`ifdef MACHINE_TIMER_PRESCALER_EN
        m_phase = tmw ? 0 : (m_phase + 1) % P;
        tick    = !tmw && m_phase == 0;
`else
        tick = !tmw;
`endif
        if (st)
            case (off)
                5'h00:   m_mtime[31:0]  = mrg(m_mtime[31:0], request_write_data, request_strobe);
                5'h04:   m_mtime[63:32] = mrg(m_mtime[63:32], request_write_data, request_strobe);
                5'h08:   m_cmp[31:0]    = mrg(m_cmp[31:0], request_write_data, request_strobe);
                5'h0C:   m_cmp[63:32]   = mrg(m_cmp[63:32], request_write_data, request_strobe);
                default: if (request_strobe[0]) m_msip = request_write_data[0];
            endcase
        if (tick) m_mtime = m_mtime + 64'd1;
    endtask

    // Model advances on the same edge the DUT samples
    always @(posedge clock) model_cycle();

    // Every cycle: DUT outputs against the model
    always @(negedge clock) begin
        if (chk_en) begin
            chk("mtime", mtime, m_mtime);
            chk("mtimecmp", mtimecmp, m_cmp);
            chk("msip", 64'(software_interrupt), 64'(m_msip));
            chk("timer_irq", 64'(timer_interrupt), 64'(m_mtime >= m_cmp));
            chk("resp_valid", 64'(response_valid), 64'(m_rv));
            if (m_rv) begin
                chk("resp_data", 64'(response_read_data), 64'(m_rd));
                chk("resp_error", 64'(response_error), 64'(m_re));
            end
        end
    end

    task automatic req(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        request_valid      = 1'b1;
        request_write      = w;
        request_address    = a;
        request_strobe     = s;
        request_write_data = d;
        @(posedge clock);
        #1;
        request_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        idle(2);
        reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle(3);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        chk("rst_mtime", mtime, 64'd0);
        chk("rst_mtimecmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_resp_valid", 64'(response_valid), 64'd0);

        idle(10);
        chk("idle10_mtime", mtime, 64'(10 / TPC));
        chk("idle10_tirq", 64'(timer_interrupt), 64'd0);
        chk("idle10_sirq", 64'(software_interrupt), 64'd0);
        req(1'b0, BASE + 32'h0C, 4'h0, 32'd0);
        chk("rd_cmphi_valid", 64'(response_valid), 64'd1);
        chk("rd_cmphi_data", 64'(response_read_data), 64'hFFFF_FFFF);

        req(1'b1, BASE + 32'h08, 4'hF, 32'd20);
        req(1'b1, BASE + 32'h0C, 4'hF, 32'd0);
        chk("cmp_is_20", mtimecmp, 64'd20);
        for (int i = 0; i < 200 && mtime < 64'd20; i++) idle(1);
        chk("tirq_at_mtime", mtime, 64'd20);
        chk("tirq_rise", 64'(timer_interrupt), 64'd1);
        req(1'b1, BASE + 32'h08, 4'hF, 32'd100);
        chk("tirq_fall", 64'(timer_interrupt), 64'd0);

        req(1'b1, BASE + 32'h00, 4'hF, 32'hFFFF_FFFF);
        req(1'b1, BASE + 32'h04, 4'hF, 32'd0);
        chk("carry_pre", mtime, 64'h0000_0000_FFFF_FFFF);
        idle(TPC);
        chk("carry", mtime, 64'h1_0000_0000);
        req(1'b1, BASE + 32'h00, 4'hF, 32'hFFFF_FFFF);
        req(1'b1, BASE + 32'h04, 4'hF, 32'hFFFF_FFFF);
        chk("all_ones", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(TPC);
        chk("wrap", mtime, 64'd0);

        req(1'b1, BASE + 32'h10, 4'b0001, 32'd1);
        chk("msip_set", 64'(software_interrupt), 64'd1);
        req(1'b0, BASE + 32'h10, 4'h0, 32'd0);
        chk("msip_read", 64'(response_read_data), 64'd1);
        req(1'b1, BASE + 32'h10, 4'b0000, 32'd0);
        chk("msip_nostrobe", 64'(software_interrupt), 64'd1);
        req(1'b0, BASE + 32'h14, 4'h0, 32'd0);
        chk("unmapped_data", 64'(response_read_data), 64'd0);
        chk("unmapped_err", 64'(response_error), 64'd1);
        req(1'b0, BASE + 32'h02, 4'h0, 32'd0);
        chk("misaligned_err", 64'(response_error), 64'd1);
        req(1'b1, BASE + 32'h09, 4'hF, 32'd0);
        chk("misaligned_nowrite", mtimecmp, 64'd100);

`ifdef MACHINE_TIMER_PRESCALER_EN
        do_reset();
        idle(12);
        chk("presc_12", mtime, 64'd3);
        idle(2);
        req(1'b1, BASE + 32'h00, 4'hF, 32'd0);
        idle(3);
        chk("presc_phase_hold", mtime, 64'd0);
        idle(1);
        chk("presc_phase_tick", mtime, 64'd1);
`endif

        req(1'b1, BASE + 32'h10, 4'b0001, 32'd1);
        request_valid   = 1'b1;
        request_write   = 1'b0;
        request_address = BASE;
        #2;
        reset_n = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        request_valid = 1'b0;
        chk("rstpulse_valid", 64'(response_valid), 64'd0);
        chk("rstpulse_mtime", mtime, 64'd0);
        chk("rstpulse_cmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rstpulse_msip", 64'(software_interrupt), 64'd0);
        reset_n = 1'b1;
        idle(1);
        chk("rstpulse_after", 64'(response_valid), 64'd0);

        for (int n = 0; n < 1500; n++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            request_address = BASE + 32'($urandom_range(0, 7) * 4);
            if (r < 8) request_address = request_address | 32'($urandom_range(1, 3));
            else if (r < 12) request_address = $urandom;
            request_valid      = $urandom_range(0, 3) != 0;
            request_write      = $urandom_range(0, 1) == 1;
            request_strobe     = 4'($urandom);
            request_write_data = $urandom;
            if ($urandom_range(0, 2) == 0) request_write_data = 32'($urandom_range(0, 64));
            @(posedge clock);
            #1;
        end
        request_valid = 1'b0;
        idle(2);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
